// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full-adder cells, with a registered result copy.
// Define FULL_ADDER_OVERFLOW_EN to add the two's-complement overflow outputs ovf/ovf_q.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [WIDTH-1:0] s_q,
  output logic             c_out_q,
`ifdef FULL_ADDER_OVERFLOW_EN
  output logic             out_valid,
  output logic             ovf,
  output logic             ovf_q
`else
  output logic             out_valid
`endif
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = c_in;

  // Each generated bit is one full-adder cell; carry ripples LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_prop;
    assign w_prop         = a[i] ^ b[i];
    assign w_sum[i]       = w_prop ^ w_carry[i];
    assign w_carry[i+1]   = (a[i] & b[i]) | (w_carry[i] & w_prop);
  end

  assign s     = w_sum;
  assign c_out = w_carry[WIDTH];

  logic [WIDTH-1:0] r_sum_p1;
  logic             r_cout_p1;
  logic             r_vld_p1;

  // p0 -> p1: capture on in_valid, hold otherwise; valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_sum_p1  <= w_sum;
        r_cout_p1 <= w_carry[WIDTH];
      end
    end
  end

  assign s_q       = r_sum_p1;
  assign c_out_q   = r_cout_p1;
  assign out_valid = r_vld_p1;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic w_ovf;
  logic r_ovf_p1;

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      r_ovf_p1 <= w_ovf;
    end
  end

  assign ovf   = w_ovf;
  assign ovf_q = r_ovf_p1;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: table-driven combinational vectors at WIDTH 1/4/8, registered-path and reset
// sequences at WIDTH 8, and a queue-scoreboarded random stream at WIDTH 16.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a1, b1, cin1, iv1, s1, c1, sq1, cq1, ov1;
  logic [3:0]  a4, b4, s4, sq4;
  logic        cin4, iv4, c4, cq4, ov4;
  logic [7:0]  a8, b8, s8, sq8;
  logic        cin8, iv8, c8, cq8, ov8;
  logic [15:0] a16, b16, s16, sq16;
  logic        cin16, iv16, c16, cq16, ov16;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic        ovf1, ovfq1, ovf4, ovfq4, ovf8, ovfq8, ovf16, ovfq16;
`endif

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(cin1), .in_valid(iv1),
    .s(s1), .c_out(c1), .s_q(sq1), .c_out_q(cq1),
`ifdef FULL_ADDER_OVERFLOW_EN
    .out_valid(ov1), .ovf(ovf1), .ovf_q(ovfq1)
`else
    .out_valid(ov1)
`endif
  );

  full_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(cin4), .in_valid(iv4),
    .s(s4), .c_out(c4), .s_q(sq4), .c_out_q(cq4),
`ifdef FULL_ADDER_OVERFLOW_EN
    .out_valid(ov4), .ovf(ovf4), .ovf_q(ovfq4)
`else
    .out_valid(ov4)
`endif
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(cin8), .in_valid(iv8),
    .s(s8), .c_out(c8), .s_q(sq8), .c_out_q(cq8),
`ifdef FULL_ADDER_OVERFLOW_EN
    .out_valid(ov8), .ovf(ovf8), .ovf_q(ovfq8)
`else
    .out_valid(ov8)
`endif
  );

  full_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c_in(cin16), .in_valid(iv16),
    .s(s16), .c_out(c16), .s_q(sq16), .c_out_q(cq16),
`ifdef FULL_ADDER_OVERFLOW_EN
    .out_valid(ov16), .ovf(ovf16), .ovf_q(ovfq16)
`else
    .out_valid(ov16)
`endif
  );

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs[14];
  logic [16:0] sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] got, e;
    logic        got_ovf;

    // {c_out,s} per spec for width 1: 00,01,01,10,01,10,10,11
    vecs[0]  = '{1, 16'h0, 16'h0, 1'b0, 17'h0, 1'b0};
    vecs[1]  = '{1, 16'h0, 16'h0, 1'b1, 17'h1, 1'b1};
    vecs[2]  = '{1, 16'h0, 16'h1, 1'b0, 17'h1, 1'b0};
    vecs[3]  = '{1, 16'h0, 16'h1, 1'b1, 17'h2, 1'b0};
    vecs[4]  = '{1, 16'h1, 16'h0, 1'b0, 17'h1, 1'b0};
    vecs[5]  = '{1, 16'h1, 16'h0, 1'b1, 17'h2, 1'b0};
    vecs[6]  = '{1, 16'h1, 16'h1, 1'b0, 17'h2, 1'b1};
    vecs[7]  = '{1, 16'h1, 16'h1, 1'b1, 17'h3, 1'b0};
    vecs[8]  = '{8, 16'hFF, 16'h00, 1'b1, 17'h100, 1'b0};
    vecs[9]  = '{8, 16'h7F, 16'h01, 1'b0, 17'h080, 1'b1};
    vecs[10] = '{8, 16'h01, 16'hFF, 1'b0, 17'h100, 1'b0};
    vecs[11] = '{4, 16'hF, 16'hF, 1'b1, 17'h1F, 1'b0};
    vecs[12] = '{4, 16'h0, 16'h0, 1'b0, 17'h00, 1'b0};
    vecs[13] = '{4, 16'h8, 16'h8, 1'b0, 17'h10, 1'b1};

    rst_n = 1'b0;
    {a1, b1, cin1, iv1} = '0;
    {a4, b4, cin4, iv4} = '0;
    {a8, b8, cin8, iv8} = '0;
    {a16, b16, cin16, iv16} = '0;
    #2;
    a8 = 8'hFF; cin8 = 1'b1;
    #1;
    check("comb_in_reset_s", 64'(s8), 64'h00);
    check("comb_in_reset_c", 64'(c8), 64'h1);
    a8 = 8'h00; cin8 = 1'b0;
    #9;
    check("rst_s_q", 64'(sq8), 64'h0);
    check("rst_c_out_q", 64'(cq8), 64'h0);
    check("rst_out_valid", 64'(ov8), 64'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].w)
        1: begin a1 = vecs[i].a[0]; b1 = vecs[i].b[0]; cin1 = vecs[i].cin; end
        4: begin a4 = vecs[i].a[3:0]; b4 = vecs[i].b[3:0]; cin4 = vecs[i].cin; end
        default: begin a8 = vecs[i].a[7:0]; b8 = vecs[i].b[7:0]; cin8 = vecs[i].cin; end
      endcase
      #4;
      got = '0;
      got_ovf = 1'b0;
      case (vecs[i].w)
        1: got = {15'b0, c1, s1};
        4: got = {12'b0, c4, s4};
        default: got = {8'b0, c8, s8};
      endcase
      check($sformatf("vec%0d_w%0d", i, vecs[i].w), 64'(got), 64'(vecs[i].exp));
`ifdef FULL_ADDER_OVERFLOW_EN
      case (vecs[i].w)
        1: got_ovf = ovf1;
        4: got_ovf = ovf4;
        default: got_ovf = ovf8;
      endcase
      check($sformatf("vec%0d_ovf", i), 64'(got_ovf), 64'(vecs[i].exp_ovf));
`endif
      #1;
    end

    // Single-cycle capture, then hold with in_valid low.
    @(posedge clk); #1;
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    check("pulse_s_q", 64'(sq8), 64'h80);
    check("pulse_c_out_q", 64'(cq8), 64'h0);
    check("pulse_out_valid", 64'(ov8), 64'h1);
`ifdef FULL_ADDER_OVERFLOW_EN
    check("pulse_ovf_q", 64'(ovfq8), 64'h1);
`endif
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    @(posedge clk); #1;
    check("hold_out_valid", 64'(ov8), 64'h0);
    check("hold_s_q", 64'(sq8), 64'h80);

    // Asynchronous reset between edges; combinational path keeps tracking.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_s_q", 64'(sq8), 64'h0);
    check("async_rst_c_out_q", 64'(cq8), 64'h0);
    check("async_rst_out_valid", 64'(ov8), 64'h0);
`ifdef FULL_ADDER_OVERFLOW_EN
    check("async_rst_ovf_q", 64'(ovfq8), 64'h0);
`endif
    a8 = 8'h10; b8 = 8'h20;
    #1;
    check("rst_comb_track", 64'({c8, s8}), 64'h030);
    a8 = 8'h55; b8 = 8'h11; iv8 = 1'b1;
    @(posedge clk); #1;
    check("rst_no_capture_vld", 64'(ov8), 64'h0);
    check("rst_no_capture_s_q", 64'(sq8), 64'h0);
    #3;
    rst_n = 1'b1;
    a8 = 8'h01; b8 = 8'h02;
    @(posedge clk); #1;
    check("post_rst_vld", 64'(ov8), 64'h1);
    check("post_rst_s_q", 64'(sq8), 64'h03);
    iv8 = 1'b0;

    // Back-to-back random stream with scoreboard.
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      iv16 = 1'b1;
      e = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
      sb.push_back(e);
      #1;
      check("rnd_comb", 64'({c16, s16}), 64'(e));
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        check("rnd_sb_empty", 64'(sb.size()), 64'h1);
      end else begin
        e = sb.pop_front();
        check("rnd_out_valid", 64'(ov16), 64'h1);
        check("rnd_q", 64'({cq16, sq16}), 64'(e));
      end
    end
    iv16 = 1'b0;
    @(posedge clk); #1;
    check("rnd_tail_vld", 64'(ov16), 64'h0);
    check("rnd_sb_drain", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
